sum_drain: RTL and testbench
============================

SUM_DRAIN -- requirements
Module: sum_drain

Interface
REQ-001 SHALL have parameter C_DSIZE, default 24, width of accumulated sum words read from the sum RAM (signed two's complement).
REQ-002 SHALL have parameter C_ASIZE, default 10, sum RAM address width.
REQ-003 SHALL have parameter C_OSIZE, default 8, width of quantized output words (signed).
REQ-004 SHALL have parameter C_RD_LAT, default 3, fixed cycles from O_raddr issue to valid I_rdata.
REQ-005 SHALL have parameter C_FIFO_DEPTH, default 4, output buffer depth; legal only when C_FIFO_DEPTH >= C_RD_LAT+1.
REQ-006 SHALL have port I_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port I_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port I_start, input, 1, single-cycle pulse that starts one drain pass.
REQ-009 SHALL have port I_len, input, C_ASIZE+1, number of words to drain (0..2^C_ASIZE), sampled on accepted I_start.
REQ-010 SHALL have port I_shift, input, 5, right-shift amount for quantization, sampled on accepted I_start.
REQ-011 SHALL have port O_busy, output, 1, high from accepted start until done pulse inclusive.
REQ-012 SHALL have port O_done, output, 1, single-cycle pulse after the last word is accepted downstream.
REQ-013 SHALL have port O_raddr, output, C_ASIZE, read address to the sum RAM read port.
REQ-014 SHALL have port O_rd, output, 1, high in cycles where O_raddr is a new read request.
REQ-015 SHALL have port I_rdata, input, C_DSIZE, sum RAM read data.
REQ-016 SHALL have port O_data, output, C_OSIZE, quantized output word.
REQ-017 SHALL have port O_valid, output, 1, O_data valid.
REQ-018 SHALL have port I_ready, input, 1, downstream ready; transfer when O_valid and I_ready both high.

Function
REQ-019 SHALL implement FSM IDLE -> RUN -> FLUSH -> IDLE; IDLE->RUN on I_start with I_len>0; RUN->FLUSH after last read issued; FLUSH->IDLE on last output transfer, asserting O_done that cycle+1.
REQ-020 SHALL ignore I_start while O_busy is high.
REQ-021 SHALL, for I_start with I_len=0, pulse O_done one cycle later, issue no reads, produce no outputs.
REQ-022 SHALL issue reads at addresses 0,1,...,I_len-1 in order, one per cycle max, no wrap; I_len=2^C_ASIZE reads address 2^C_ASIZE-1 last.
REQ-023 SHALL issue a read only when (reads in flight + FIFO occupancy) < C_FIFO_DEPTH, so the FIFO never overflows.
REQ-024 SHALL track in-flight reads with a C_RD_LAT-deep valid shift register and capture I_rdata into the FIFO exactly C_RD_LAT cycles after its O_rd.
REQ-025 SHALL quantize each word: if shift s>0, add 2^(s-1) then arithmetic right shift by s; saturate to [-2^(C_OSIZE-1), 2^(C_OSIZE-1)-1]; s>=C_DSIZE yields 0 (or -1 for negative before rounding per arithmetic shift).
REQ-026 SHALL perform rounding in C_DSIZE+1 bits so no internal overflow occurs.
REQ-027 SHALL hold O_data stable while O_valid=1 and I_ready=0; O_valid SHALL not drop without a transfer.
REQ-028 SHALL sustain one output per cycle with I_ready held high after initial latency of C_RD_LAT+1 cycles from start.
REQ-029 SHALL keep O_raddr at last issued value when O_rd=0.

Reset
REQ-030 SHALL, on I_rst_n low at any time including mid-pass, asynchronously clear FSM to IDLE, O_busy=0, O_done=0, O_valid=0, O_rd=0, O_raddr=0, O_data=0, FIFO and in-flight tracking empty.
REQ-031 SHALL, after reset release, discard any I_rdata returning for pre-reset reads.

Verification
REQ-032 SHALL verify: I_len=4, I_shift=0, RAM words 1,2,3,4, I_ready=1 -> O_data 1,2,3,4 on 4 consecutive cycles, O_done one cycle after last.
REQ-033 SHALL verify: I_shift=4, words 24 and -24 -> outputs 2 and -1 (round-half-up); words 5000 and -5000 -> 127 and -128.
REQ-034 SHALL verify: I_len=16, I_ready toggling 1 of every 3 cycles -> all 16 words in order, no loss or duplicate, O_rd never issued when in-flight+occupancy=C_FIFO_DEPTH.
REQ-035 SHALL verify: I_len=0 -> O_done one cycle after start, O_rd and O_valid never high.
REQ-036 SHALL verify: I_len=1024 drain -> O_raddr reaches 1023, exactly 1024 transfers.
REQ-037 SHALL verify: I_rst_n asserted mid-pass with 3 reads in flight -> all outputs 0 immediately; new start of I_len=2 afterwards yields exactly 2 correct words.

Source files
------------

// File: rtl/sum_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sum_drain                                                       |
// | Purpose  : Drains a sum RAM, quantizes each word and streams it out.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sum_drain #(
    parameter int C_DSIZE      = 24,
    parameter int C_ASIZE      = 10,
    parameter int C_OSIZE      = 8,
    parameter int C_RD_LAT     = 3,
    parameter int C_FIFO_DEPTH = 4
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic               I_start,
    input  logic [C_ASIZE:0]   I_len,
    input  logic [4:0]         I_shift,
    output logic               O_busy,
    output logic               O_done,
    output logic [C_ASIZE-1:0] O_raddr,
    output logic               O_rd,
    input  logic [C_DSIZE-1:0] I_rdata,
    output logic [C_OSIZE-1:0] O_data,
    output logic               O_valid,
    input  logic               I_ready
);

    localparam int C_PW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
    localparam int C_CW = $clog2(C_FIFO_DEPTH + C_RD_LAT + 1) + 1;
    localparam logic signed [C_DSIZE:0] C_QMAX = (C_DSIZE+1)'((1 << (C_OSIZE-1)) - 1);
    localparam logic signed [C_DSIZE:0] C_QMIN = (C_DSIZE+1)'(-(1 << (C_OSIZE-1)));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic [C_ASIZE:0]     len_q;
    logic [C_ASIZE:0]     rd_cnt_q;
    logic [4:0]           shift_q;
    logic [C_ASIZE-1:0]   raddr_q;
    logic [C_RD_LAT-1:0]  pipe_q;
    logic [C_OSIZE-1:0]   mem_q [C_FIFO_DEPTH];
    logic [C_PW-1:0]      wr_ptr_q;
    logic [C_PW-1:0]      rd_ptr_q;
    logic [C_CW-1:0]      cnt_q;

    logic [C_CW-1:0]      w_inflight;
    logic [C_CW-1:0]      w_load;
    logic                 w_rd;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_last_rd;
    logic signed [C_DSIZE:0] w_ext;
    logic signed [C_DSIZE:0] w_half;
    logic signed [C_DSIZE:0] w_rnd;
    logic signed [C_DSIZE:0] w_shr;
    logic [C_OSIZE-1:0]   w_q;

    function automatic logic [C_PW-1:0] f_inc(input logic [C_PW-1:0] p);
        return (p == C_PW'(C_FIFO_DEPTH-1)) ? '0 : p + C_PW'(1);
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < C_RD_LAT; i++) begin
            w_inflight = w_inflight + C_CW'(pipe_q[i]);
        end
    end

    // A slot is reserved for every read from issue until its word is popped,
    // so the FIFO can never be written while full.
    assign O_valid   = (cnt_q != '0);
    assign w_pop     = O_valid && I_ready;
    assign w_push    = pipe_q[C_RD_LAT-1];
    assign w_load    = w_inflight + cnt_q - C_CW'(w_pop);
    assign w_rd      = (state_q == S_RUN) && (w_load < C_CW'(C_FIFO_DEPTH));
    assign w_last_rd = (rd_cnt_q == len_q - (C_ASIZE+1)'(1));

    assign O_rd    = w_rd;
    assign O_raddr = w_rd ? rd_cnt_q[C_ASIZE-1:0] : raddr_q;
    assign O_busy  = busy_q;
    assign O_done  = done_q;
    assign O_data  = mem_q[rd_ptr_q];

    // Round-half-up in one extra bit, then shift and saturate.
    always_comb begin
        w_ext  = {I_rdata[C_DSIZE-1], I_rdata};
        w_half = (shift_q == 5'd0) ? '0 : ((C_DSIZE+1)'(1) << (shift_q - 5'd1));
        w_rnd  = w_ext + w_half;
        w_shr  = w_rnd >>> shift_q;
        if (32'(shift_q) >= C_DSIZE) begin
            w_q = I_rdata[C_DSIZE-1] ? '1 : '0;
        end else if (w_shr > C_QMAX) begin
            w_q = C_QMAX[C_OSIZE-1:0];
        end else if (w_shr < C_QMIN) begin
            w_q = C_QMIN[C_OSIZE-1:0];
        end else begin
            w_q = w_shr[C_OSIZE-1:0];
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            len_q    <= '0;
            rd_cnt_q <= '0;
            shift_q  <= '0;
            raddr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (done_q) begin
                busy_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (I_start && !busy_q) begin
                        busy_q   <= 1'b1;
                        len_q    <= I_len;
                        shift_q  <= I_shift;
                        rd_cnt_q <= '0;
                        if (I_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_rd) begin
                        rd_cnt_q <= rd_cnt_q + (C_ASIZE+1)'(1);
                        raddr_q  <= rd_cnt_q[C_ASIZE-1:0];
                        if (w_last_rd) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_pop && (cnt_q == C_CW'(1)) && (pipe_q == '0)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    generate
        if (C_RD_LAT == 1) begin : g_pipe_one
            always_ff @(posedge I_clk or negedge I_rst_n) begin
                if (!I_rst_n) pipe_q <= '0;
                else          pipe_q <= w_rd;
            end
        end else begin : g_pipe_deep
            always_ff @(posedge I_clk or negedge I_rst_n) begin
                if (!I_rst_n) pipe_q <= '0;
                else          pipe_q <= {pipe_q[C_RD_LAT-2:0], w_rd};
            end
        end
    endgenerate

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < C_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= w_q;
                wr_ptr_q        <= f_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= f_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + C_CW'(w_push) - C_CW'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sum_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sum_drain                                                    |
// | Purpose  : Directed self-checking bench for sum_drain.                     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sum_drain;

    localparam int C_DEPTH = 4;

    logic        I_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic        I_start = 1'b0;
    logic [10:0] I_len = '0;
    logic [4:0]  I_shift = '0;
    logic        O_busy, O_done, O_rd, O_valid;
    logic [9:0]  O_raddr;
    logic [23:0] I_rdata;
    logic [7:0]  O_data;
    logic        I_ready = 1'b1;

    sum_drain dut (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_start (I_start),
        .I_len   (I_len),
        .I_shift (I_shift),
        .O_busy  (O_busy),
        .O_done  (O_done),
        .O_raddr (O_raddr),
        .O_rd    (O_rd),
        .I_rdata (I_rdata),
        .O_data  (O_data),
        .O_valid (O_valid),
        .I_ready (I_ready)
    );

    always #5 I_clk = ~I_clk;

    // Sum RAM model: data for a read in cycle t is presented in cycle t+3.
    logic [23:0] ram [0:1023];
    logic [9:0]  a0 = '0, a1 = '0, a2 = '0;
    always @(posedge I_clk) begin
        a0 <= O_raddr;
        a1 <= a0;
        a2 <= a1;
    end
    assign I_rdata = ram[a2];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic       mon_clr = 1'b0;
    int         cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    int         n_xfer = 0, n_iss = 0, exp_addr = 0, ovf = 0, addr_err = 0;
    int         hold_err = 0, valid_cnt = 0, first_xfer = 0, last_xfer = 0, last_addr = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] got_mem [0:2047];

    always @(posedge I_clk) begin
        cyc <= cyc + 1;
        if (O_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (I_start) start_cyc <= cyc;
        if (mon_clr) begin
            n_xfer    <= 0;
            n_iss     <= 0;
            exp_addr  <= 0;
            ovf       <= 0;
            addr_err  <= 0;
            hold_err  <= 0;
            valid_cnt <= 0;
            prev_hold <= 1'b0;
            last_addr <= -1;
        end else begin
            if (O_valid) valid_cnt <= valid_cnt + 1;
            if (O_valid && I_ready) begin
                got_mem[n_xfer] <= O_data;
                n_xfer          <= n_xfer + 1;
                last_xfer       <= cyc;
                if (n_xfer == 0) first_xfer <= cyc;
            end
            if (O_rd) begin
                if (int'(O_raddr) != exp_addr) addr_err <= addr_err + 1;
                exp_addr  <= exp_addr + 1;
                n_iss     <= n_iss + 1;
                last_addr <= int'(O_raddr);
            end
            if ((n_iss + int'(O_rd)) - (n_xfer + int'(O_valid && I_ready)) > C_DEPTH)
                ovf <= ovf + 1;
            if (prev_hold && (!O_valid || O_data != prev_data))
                hold_err <= hold_err + 1;
            prev_hold <= O_valid && !I_ready;
            prev_data <= O_data;
        end
    end

    task automatic clear_mon();
        @(negedge I_clk) mon_clr = 1'b1;
        @(negedge I_clk) mon_clr = 1'b0;
    endtask

    task automatic do_start(input int len, input int sh);
        @(negedge I_clk);
        I_start = 1'b1;
        I_len   = 11'(len);
        I_shift = 5'(sh);
        @(negedge I_clk);
        I_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int  d0;
        bit  seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge I_clk);
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_pass(input string tag, input int len, input int sh);
        clear_mon();
        I_ready = 1'b1;
        do_start(len, sh);
        wait_done(tag, len + 40);
    endtask

    initial begin
        int errs;
        int d0;
        for (int i = 0; i < 1024; i++) ram[i] = '0;

        repeat (3) @(negedge I_clk);
        I_rst_n = 1'b1;
        @(negedge I_clk);
        check("rst_busy",  32'(O_busy),  32'd0);
        check("rst_done",  32'(O_done),  32'd0);
        check("rst_valid", 32'(O_valid), 32'd0);
        check("rst_rd",    32'(O_rd),    32'd0);
        check("rst_raddr", 32'(O_raddr), 32'd0);
        check("rst_data",  32'(O_data),  32'd0);

        // Basic pass-through with no shift
        for (int i = 0; i < 4; i++) ram[i] = 24'(i + 1);
        run_pass("basic", 4, 0);
        check("basic_count", 32'(n_xfer), 32'd4);
        for (int i = 0; i < 4; i++) check("basic_data", 32'(got_mem[i]), 32'(i + 1));
        check("basic_back2back", 32'(last_xfer - first_xfer), 32'd3);
        check("basic_done_lat",  32'(done_cyc - last_xfer),   32'd1);
        @(negedge I_clk);
        check("basic_busy_after", 32'(O_busy), 32'd0);

        // Rounding and saturation
        ram[0] = 24'(24); ram[1] = 24'(-24); ram[2] = 24'(5000); ram[3] = 24'(-5000);
        run_pass("quant4", 4, 4);
        check("q4_pos_round", 32'(got_mem[0]), 32'h02);
        check("q4_neg_round", 32'(got_mem[1]), 32'hFF);
        check("q4_sat_hi",    32'(got_mem[2]), 32'h7F);
        check("q4_sat_lo",    32'(got_mem[3]), 32'h80);
        ram[0] = 24'(100); ram[1] = 24'(-100);
        run_pass("quant30", 2, 30);
        check("q30_pos", 32'(got_mem[0]), 32'h00);
        check("q30_neg", 32'(got_mem[1]), 32'hFF);
        ram[0] = 24'(3); ram[1] = 24'(-5);
        run_pass("quant1", 2, 1);
        check("q1_pos", 32'(got_mem[0]), 32'h02);
        check("q1_neg", 32'(got_mem[1]), 32'hFE);

        // Back-pressure: ready high one cycle in three
        for (int i = 0; i < 16; i++) ram[i] = 24'(i * 3 + 1);
        clear_mon();
        I_ready = 1'b0;
        do_start(16, 0);
        d0 = done_cnt;
        for (int k = 0; k < 300; k++) begin
            @(negedge I_clk);
            I_ready = (k % 3 == 0);
            if (done_cnt != d0) break;
        end
        check("bp_done_seen", 32'(done_cnt - d0), 32'd1);
        I_ready = 1'b1;
        check("bp_count", 32'(n_xfer), 32'd16);
        errs = 0;
        for (int i = 0; i < 16; i++) if (got_mem[i] != 8'(i * 3 + 1)) errs++;
        check("bp_data_errs", 32'(errs), 32'd0);
        check("bp_overflow",  32'(ovf), 32'd0);
        check("bp_addr_errs", 32'(addr_err), 32'd0);
        check("bp_hold_errs", 32'(hold_err), 32'd0);

        // Zero-length pass
        run_pass("len0", 0, 0);
        check("len0_done_lat", 32'(done_cyc - start_cyc), 32'd1);
        check("len0_reads",    32'(n_iss), 32'd0);
        check("len0_valids",   32'(valid_cnt), 32'd0);

        // Full-size drain
        for (int i = 0; i < 1024; i++) ram[i] = 24'((i % 200) - 100);
        run_pass("len1024", 1024, 0);
        check("full_count",     32'(n_xfer), 32'd1024);
        check("full_last_addr", 32'(last_addr), 32'd1023);
        check("full_addr_errs", 32'(addr_err), 32'd0);
        errs = 0;
        for (int i = 0; i < 1024; i++) if (got_mem[i] != 8'((i % 200) - 100)) errs++;
        check("full_data_errs", 32'(errs), 32'd0);

        // Reset with three reads outstanding, then a fresh short pass
        for (int i = 0; i < 8; i++) ram[i] = 24'(10 + i);
        clear_mon();
        I_ready = 1'b0;
        do_start(8, 0);
        for (int k = 0; k < 20; k++) begin
            if (n_iss >= 3) break;
            @(negedge I_clk);
        end
        check("mid_inflight", 32'(n_iss - n_xfer), 32'd3);
        I_rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(O_busy),  32'd0);
        check("mid_rst_done",  32'(O_done),  32'd0);
        check("mid_rst_valid", 32'(O_valid), 32'd0);
        check("mid_rst_rd",    32'(O_rd),    32'd0);
        check("mid_rst_raddr", 32'(O_raddr), 32'd0);
        check("mid_rst_data",  32'(O_data),  32'd0);
        @(negedge I_clk);
        I_rst_n = 1'b1;
        clear_mon();
        repeat (4) @(negedge I_clk);
        check("stale_discard", 32'(valid_cnt), 32'd0);
        ram[0] = 24'(77); ram[1] = 24'(-9);
        run_pass("restart", 2, 0);
        check("restart_count", 32'(n_xfer), 32'd2);
        check("restart_w0",    32'(got_mem[0]), 32'h4D);
        check("restart_w1",    32'(got_mem[1]), 32'hF7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
